tis_instr_mem_loader: RTL

TIS_INSTR_MEM_LOADER -- requirements
Module: tis_instr_mem_loader

---
 rtl/tis_instr_mem_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/tis_instr_mem_loader.sv
// Program loader and instruction memory for a TIS100 core: streams a program in,
// then releases the core from reset and serves combinational instruction fetches.
module tis_instr_mem_loader #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned DEPTH   = 15,
    parameter int unsigned AW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic [AW-1:0]      Addr_instr,
    output logic [INSTR_W-1:0] instr,
    output logic               core_rst_n,
    output logic [AW-1:0]      prog_len,
    output logic               load_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StErr} state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      wp_q, wp_d;
    logic [AW-1:0]      prog_len_q, prog_len_d;
    logic               load_err_q, load_err_d;
    logic               core_rst_n_q, core_rst_n_d;
    logic               accept;
    logic               at_end;
    logic [INSTR_W-1:0] mem_q [DEPTH];

    // load_start wins over a simultaneous word, so that word is never accepted
    assign accept = (state_q == StLoad) && load_valid && !load_start;
    assign at_end = (wp_q == AW'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_start) state_d = StLoad;
            end
            StLoad: begin
                if (load_start) begin
                    state_d = StLoad;
                end else if (accept && load_last) begin
                    state_d = StRun;
                end else if (accept && at_end) begin
                    state_d = StErr;
                end
            end
            StRun: begin
                if (load_start) state_d = StLoad;
            end
            StErr: begin
                if (load_start) state_d = StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    // Core leaves reset only once RUN has been registered and is being held
    always_comb begin
        load_ready   = (state_q == StLoad);
        core_rst_n_d = (state_q == StRun) && (state_d == StRun);
    end

    always_comb begin
        wp_d       = wp_q;
        prog_len_d = prog_len_q;
        load_err_d = load_err_q;
        if (load_start) begin
            wp_d       = '0;
            prog_len_d = '0;
            load_err_d = 1'b0;
        end else if (accept) begin
            wp_d = wp_q + AW'(1);
            if (load_last) begin
                prog_len_d = wp_q + AW'(1);
            end else if (at_end) begin
                prog_len_d = '0;
                load_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q         <= '0;
            prog_len_q   <= '0;
            load_err_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            prog_len_q   <= prog_len_d;
            load_err_q   <= load_err_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wp_q] <= load_data;
        end
    end

    // Addresses at or beyond prog_len read as NOP; prog_len never exceeds DEPTH
    always_comb begin
        instr = '0;
        if (Addr_instr < prog_len_q) begin
            instr = mem_q[Addr_instr];
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign prog_len   = prog_len_q;
    assign load_err   = load_err_q;

endmodule
